// File: rtl/stream_insert_hdr_arb_if.sv
// -----------------------------------------------------------------------------
// stream_insert_hdr_arb_if
//
// Bundle for the header arbiter. It carries two groups of signals:
//   * requester side: req_valid / req_data / req_keep / req_byte_cnt in,
//     req_ready (one-hot) out, all packed NUM_REQ-wide with requester i in
//     slice [i*W +: W];
//   * insert side: valid_insert / data_insert / keep_insert / byte_insert_cnt
//     toward stream_insert, ready_insert back from it.
//
// Modports:
//   master - the arbiter itself (consumes requests, drives the insert port)
//   slave  - the surroundings (requesters plus stream_insert)
// -----------------------------------------------------------------------------
interface stream_insert_hdr_arb_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 4
) ();

  // Requester side
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*DATA_WD-1:0]      req_data;
  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep;
  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt;
  logic [NUM_REQ-1:0]              req_ready;

  // Insert side (toward stream_insert)
  logic                            valid_insert;
  logic [DATA_WD-1:0]              data_insert;
  logic [DATA_BYTE_WD-1:0]         keep_insert;
  logic [BYTE_CNT_WD-1:0]          byte_insert_cnt;
  logic                            ready_insert;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_keep,
    input  req_byte_cnt,
    output req_ready,
    output valid_insert,
    output data_insert,
    output keep_insert,
    output byte_insert_cnt,
    input  ready_insert
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_keep,
    output req_byte_cnt,
    input  req_ready,
    input  valid_insert,
    input  data_insert,
    input  keep_insert,
    input  byte_insert_cnt,
    output ready_insert
  );

endinterface

// File: rtl/stream_insert_hdr_arb.sv
// -----------------------------------------------------------------------------
// stream_insert_hdr_arb
//
// Shares the single header-insert port of stream_insert among NUM_REQ header
// requesters. A round-robin arbiter picks one requester, its header is latched
// into registered insert outputs, and the grant is held until stream_insert
// reports the last beat of that packet. Exactly one header is therefore
// inserted per output packet.
//
// Ports:
//   clk            - clock, rising edge
//   rstn           - asynchronous active-low reset
//   bus (master)   - requester bundle and insert port (see interface)
//   pkt_last_fire  - last beat of the current packet left stream_insert
//   grant_id       - index of the current owner (registered)
//   busy           - a header is being offered or its packet is in flight
//   proto_err      - sticky: pkt_last_fire seen while no packet was open
//
// req_ready is the only combinational output: it strobes the winner in the
// same cycle the header is captured. All insert outputs are registered, so
// there is no path from ready_insert back to valid_insert/data_insert.
// -----------------------------------------------------------------------------
module stream_insert_hdr_arb #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 4,
  parameter int ID_WD        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  stream_insert_hdr_arb_if.master   bus,
  input  logic                      pkt_last_fire,
  output logic [ID_WD-1:0]          grant_id,
  output logic                      busy,
  output logic                      proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no owner
    ST_HDR  = 2'd1,   // header offered on the insert port
    ST_PKT  = 2'd2    // header taken, waiting for the packet's last beat
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;

  logic [ID_WD-1:0]         rr_ptr_r;
  logic [ID_WD-1:0]         rr_nxt_s;
  logic [ID_WD-1:0]         cand_s;
  logic [ID_WD-1:0]         winner_s;
  logic                     any_req_s;
  logic                     grant_s;
  logic                     err_set_s;
  logic                     valid_nxt_s;
  logic                     busy_nxt_s;
  logic [NUM_REQ-1:0]       req_ready_s;

  logic                     valid_insert_r;
  logic [DATA_WD-1:0]       data_insert_r;
  logic [DATA_BYTE_WD-1:0]  keep_insert_r;
  logic [BYTE_CNT_WD-1:0]   byte_cnt_r;
  logic [ID_WD-1:0]         grant_id_r;
  logic                     busy_r;
  logic                     proto_err_r;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    any_req_s = 1'b0;
    winner_s  = '0;
    cand_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = ID_WD'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!any_req_s && bus.req_valid[cand_s]) begin
        any_req_s = 1'b1;
        winner_s  = cand_s;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        // valid_insert is high throughout HDR, so ready_insert alone
        // completes the header handshake. A stray pkt_last_fire is ignored.
        if (bus.ready_insert) begin
          state_nxt_s = ST_PKT;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_PKT: begin
        if (pkt_last_fire) begin
          // Back-to-back: re-arbitrate in the same cycle as the last beat.
          if (any_req_s) begin
            state_nxt_s = ST_HDR;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_PKT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode: grant strobe, error detection and next register values.
  always_comb begin
    grant_s   = 1'b0;
    err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_s   = any_req_s;
        err_set_s = pkt_last_fire;
      end
      ST_HDR: begin
        grant_s   = 1'b0;
        err_set_s = pkt_last_fire;
      end
      ST_PKT: begin
        grant_s   = pkt_last_fire && any_req_s;
        err_set_s = 1'b0;
      end
      default: begin
        grant_s   = 1'b0;
        err_set_s = 1'b0;
      end
    endcase

    req_ready_s = '0;
    if (grant_s) begin
      req_ready_s[winner_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end

    if (winner_s == ID_WD'(NUM_REQ - 1)) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = winner_s + ID_WD'(1);
    end

    valid_nxt_s = (state_nxt_s == ST_HDR);
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
  end

  // Registered outputs and round-robin pointer; header fields load on grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_insert_r <= 1'b0;
      data_insert_r  <= '0;
      keep_insert_r  <= '0;
      byte_cnt_r     <= '0;
      grant_id_r     <= '0;
      busy_r         <= 1'b0;
      proto_err_r    <= 1'b0;
      rr_ptr_r       <= '0;
    end else begin
      valid_insert_r <= valid_nxt_s;
      busy_r         <= busy_nxt_s;
      if (err_set_s) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
      if (grant_s) begin
        data_insert_r <= bus.req_data[int'(winner_s)*DATA_WD +: DATA_WD];
        keep_insert_r <= bus.req_keep[int'(winner_s)*DATA_BYTE_WD +: DATA_BYTE_WD];
        byte_cnt_r    <= bus.req_byte_cnt[int'(winner_s)*BYTE_CNT_WD +: BYTE_CNT_WD];
        grant_id_r    <= winner_s;
        rr_ptr_r      <= rr_nxt_s;
      end else begin
        data_insert_r <= data_insert_r;
        keep_insert_r <= keep_insert_r;
        byte_cnt_r    <= byte_cnt_r;
        grant_id_r    <= grant_id_r;
        rr_ptr_r      <= rr_ptr_r;
      end
    end
  end

  assign bus.req_ready       = req_ready_s;
  assign bus.valid_insert    = valid_insert_r;
  assign bus.data_insert     = data_insert_r;
  assign bus.keep_insert     = keep_insert_r;
  assign bus.byte_insert_cnt = byte_cnt_r;
  assign grant_id            = grant_id_r;
  assign busy                = busy_r;
  assign proto_err           = proto_err_r;

endmodule

// File: tb/tb_stream_insert_hdr_arb.sv
// -----------------------------------------------------------------------------
// tb_stream_insert_hdr_arb
//
// Bench for stream_insert_hdr_arb. A reference model (negedge, plain integer
// bookkeeping) predicts req_ready and the registered status outputs and pushes
// every granted header into a scoreboard queue; an independent monitor pops
// and compares whenever the insert handshake fires. Directed scenarios cover
// the listed cases, followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_stream_insert_hdr_arb;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int NR = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          pkt_last_fire;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          proto_err;

  stream_insert_hdr_arb_if #(
    .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW), .NUM_REQ(NR)
  ) bus ();

  stream_insert_hdr_arb #(
    .DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW), .NUM_REQ(NR), .ID_WD(IW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus),
    .pkt_last_fire (pkt_last_fire),
    .grant_id      (grant_id),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic [CW-1:0] c;
  } hdr_t;

  hdr_t exp_q[$];
  int   dut_grants[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ptr;
  bit m_offer;
  bit m_inpkt;
  bit m_err;
  int m_owner;

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (p + k) % NR;
      if (v[IW'(i)]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit g;
    logic [NR-1:0] er;
    hdr_t h;
    if (!rstn) begin
      m_ptr = 0; m_offer = 0; m_inpkt = 0; m_err = 0; m_owner = 0;
      exp_q.delete();
    end else begin
      chk("valid_insert", 64'(bus.valid_insert), 64'(m_offer));
      chk("busy", 64'(busy), 64'(m_offer | m_inpkt));
      chk("grant_id", 64'(grant_id), 64'(m_owner));
      chk("proto_err", 64'(proto_err), 64'(m_err));
      w  = pick(bus.req_valid, m_ptr);
      g  = (w >= 0) && ((!m_offer && !m_inpkt) || (m_inpkt && pkt_last_fire));
      er = '0;
      if (g) er[IW'(w)] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      if (pkt_last_fire && !m_inpkt) m_err = 1;
      if (m_offer && bus.ready_insert) begin
        m_offer = 0; m_inpkt = 1;
      end else if (m_inpkt && pkt_last_fire) begin
        m_inpkt = 0;
      end
      if (g) begin
        m_offer = 1; m_inpkt = 0; m_owner = w; m_ptr = (w + 1) % NR;
        h.id = w;
        h.d  = bus.req_data[w*DW +: DW];
        h.k  = bus.req_keep[w*BW +: BW];
        h.c  = bus.req_byte_cnt[w*CW +: CW];
        exp_q.push_back(h);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit            stall;
    logic [DW-1:0] sd;
    logic [BW-1:0] sk;
    logic [CW-1:0] sc;
    hdr_t          h;
    stall = 0; sd = '0; sk = '0; sc = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall = 0;
      end else begin
        for (int k = 0; k < NR; k++) begin
          if (bus.req_ready[IW'(k)]) dut_grants.push_back(k);
        end
        if (stall) begin
          chk("hold_valid", 64'(bus.valid_insert), 64'd1);
          chk("hold_data", 64'(bus.data_insert), 64'(sd));
          chk("hold_keep", 64'(bus.keep_insert), 64'(sk));
          chk("hold_cnt", 64'(bus.byte_insert_cnt), 64'(sc));
        end
        if (bus.valid_insert && bus.ready_insert) begin
          chk("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            h = exp_q.pop_front();
            chk("sb_data", 64'(bus.data_insert), 64'(h.d));
            chk("sb_keep", 64'(bus.keep_insert), 64'(h.k));
            chk("sb_cnt", 64'(bus.byte_insert_cnt), 64'(h.c));
            chk("sb_id", 64'(grant_id), 64'(h.id));
          end
        end
        stall = bus.valid_insert && !bus.ready_insert;
        sd = bus.data_insert; sk = bus.keep_insert; sc = bus.byte_insert_cnt;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    rstn = 1'b0;
    bus.req_valid = '0;
    pkt_last_fire = 1'b0;
    bus.ready_insert = 1'b1;
    repeat (2) @(negedge clk);
    nxt();
    rstn = 1'b1;
    dut_grants.delete();
  endtask

  task automatic rand_hdrs();
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = $urandom;
    bus.req_keep     = NR*BW'($urandom);
    bus.req_byte_cnt = NR*CW'($urandom);
  endtask

  // Emulates stream_insert: after each header handshake, a packet of len
  // beats (random 1..4 when len==0) ends with a pkt_last_fire pulse.
  task automatic run_auto(input int ncyc, input int len, input bit rnd_req, input bit rnd_rdy);
    bit hs;
    int beats;
    int between;
    logic [NR-1:0] v;
    hs = 0; beats = 0; between = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (hs) beats = (len > 0) ? len : int'($urandom_range(4, 1));
      if (beats > 0) begin
        beats--;
        pkt_last_fire = (beats == 0);
      end else begin
        pkt_last_fire = 1'b0;
      end
      if (rnd_req) begin
        v = bus.req_valid;
        for (int i = 0; i < NR; i++) begin
          if ($urandom_range(3, 0) == 0) v[IW'(i)] = ~v[IW'(i)];
        end
        bus.req_valid = v;
        rand_hdrs();
      end
      if (rnd_rdy) bus.ready_insert = ($urandom_range(2, 0) != 0);
      smp();
      if (pkt_last_fire) begin
        chk("hs_per_pkt", 64'(between), 64'd1);
        between = 0;
      end
      hs = bus.valid_insert && bus.ready_insert;
      if (hs) between++;
      nxt();
    end
    pkt_last_fire = 1'b0;
  endtask

  // Watchdog: the run is bounded by fixed loops; this only catches a hang.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int exp_rr[6];
    rstn = 1'b0;
    pkt_last_fire = 1'b0;
    bus.req_valid = '0;
    bus.ready_insert = 1'b1;
    rand_hdrs();

    // Reset state
    do_reset();
    smp();
    chk("rst_valid", 64'(bus.valid_insert), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_data", 64'(bus.data_insert), 64'd0);
    chk("rst_keep", 64'(bus.keep_insert), 64'd0);
    chk("rst_cnt", 64'(bus.byte_insert_cnt), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // Single requester
    nxt();
    bus.req_data[2*DW +: DW] = 32'hA5A5_0001;
    bus.req_keep[2*BW +: BW] = 4'b0011;
    bus.req_byte_cnt[2*CW +: CW] = 2'd2;
    bus.req_valid = 4'b0100;
    bus.ready_insert = 1'b1;
    smp();
    chk("single_req_ready", 64'(bus.req_ready), 64'b0100);
    nxt();
    bus.req_valid = 4'b0000;
    smp();
    chk("single_valid", 64'(bus.valid_insert), 64'd1);
    chk("single_data", 64'(bus.data_insert), 64'hA5A5_0001);
    chk("single_cnt", 64'(bus.byte_insert_cnt), 64'd2);
    chk("single_gid", 64'(grant_id), 64'd2);
    nxt();
    smp();
    chk("single_pkt_busy", 64'(busy), 64'd1);
    chk("single_pkt_valid", 64'(bus.valid_insert), 64'd0);
    nxt();
    pkt_last_fire = 1'b1;
    smp();
    nxt();
    pkt_last_fire = 1'b0;
    smp();
    chk("single_idle", 64'(busy), 64'd0);

    // All four requesting, 3-beat packets
    do_reset();
    bus.req_valid = 4'b1111;
    bus.ready_insert = 1'b1;
    run_auto(40, 3, 1'b0, 1'b0);
    exp_rr = '{0, 1, 2, 3, 0, 1};
    chk("rr_count", 64'(dut_grants.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < dut_grants.size()) chk("rr_order", 64'(dut_grants[i]), 64'(exp_rr[i]));
    end

    // Fairness skip: grant to 0 moves the pointer to 1, then 3, then 0
    do_reset();
    bus.req_valid = 4'b1001;
    run_auto(20, 2, 1'b0, 1'b0);
    chk("skip_count", 64'(dut_grants.size() >= 3), 64'd1);
    if (dut_grants.size() >= 3) begin
      chk("skip_g0", 64'(dut_grants[0]), 64'd0);
      chk("skip_g1", 64'(dut_grants[1]), 64'd3);
      chk("skip_g2", 64'(dut_grants[2]), 64'd0);
    end

    // Backpressure: 5 stalled cycles in HDR
    do_reset();
    bus.req_data[1*DW +: DW] = 32'h1234_5678;
    bus.req_keep[1*BW +: BW] = 4'b1111;
    bus.req_valid = 4'b0010;
    bus.ready_insert = 1'b0;
    smp();
    chk("bp_req_ready", 64'(bus.req_ready), 64'b0010);
    nxt();
    bus.req_valid = 4'b0000;
    bus.req_data[1*DW +: DW] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_valid", 64'(bus.valid_insert), 64'd1);
      chk("bp_data", 64'(bus.data_insert), 64'h1234_5678);
      chk("bp_keep", 64'(bus.keep_insert), 64'hF);
      nxt();
    end
    bus.ready_insert = 1'b1;
    smp();
    chk("bp_still_hdr", 64'(bus.valid_insert), 64'd1);
    nxt();
    smp();
    chk("bp_pkt_valid", 64'(bus.valid_insert), 64'd0);
    chk("bp_pkt_busy", 64'(busy), 64'd1);

    // Protocol error: pkt_last_fire while in HDR
    do_reset();
    bus.req_valid = 4'b0001;
    bus.ready_insert = 1'b0;
    smp();
    nxt();
    bus.req_valid = 4'b0000;
    pkt_last_fire = 1'b1;
    smp();
    nxt();
    pkt_last_fire = 1'b0;
    smp();
    chk("perr_set", 64'(proto_err), 64'd1);
    chk("perr_stay_hdr", 64'(bus.valid_insert), 64'd1);
    nxt();
    bus.ready_insert = 1'b1;
    smp();
    nxt();
    pkt_last_fire = 1'b1;
    smp();
    nxt();
    pkt_last_fire = 1'b0;
    repeat (3) nxt();
    smp();
    chk("perr_sticky", 64'(proto_err), 64'd1);
    chk("perr_idle", 64'(busy), 64'd0);

    // Reset mid-PKT with grant_id=3
    do_reset();
    smp();
    chk("perr_cleared", 64'(proto_err), 64'd0);
    nxt();
    bus.req_valid = 4'b1000;
    bus.ready_insert = 1'b1;
    smp();
    nxt();
    bus.req_valid = 4'b0000;
    smp();
    nxt();
    smp();
    chk("mid_gid", 64'(grant_id), 64'd3);
    chk("mid_busy", 64'(busy), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.valid_insert), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_gid", 64'(grant_id), 64'd0);
    chk("arst_data", 64'(bus.data_insert), 64'd0);
    chk("arst_keep", 64'(bus.keep_insert), 64'd0);
    chk("arst_cnt", 64'(bus.byte_insert_cnt), 64'd0);
    chk("arst_err", 64'(proto_err), 64'd0);
    chk("arst_ready", 64'(bus.req_ready), 64'd0);
    nxt();
    smp();
    nxt();
    rstn = 1'b1;
    dut_grants.delete();
    bus.req_valid = 4'b1000;
    smp();
    chk("post_rst_ready", 64'(bus.req_ready), 64'b1000);
    nxt();
    bus.req_valid = 4'b0000;
    smp();
    chk("post_rst_gid", 64'(grant_id), 64'd3);

    // Randomized run against the model
    do_reset();
    bus.req_valid = '0;
    run_auto(3000, 0, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_insert_hdr_arb.md
# stream_insert_hdr_arb

Header-source arbiter and sequencer in front of `stream_insert`. It shares the single insert port among `NUM_REQ` header requesters using round-robin arbitration. It latches one header per packet and holds the grant until `stream_insert` has emitted that packet's last beat, so exactly one header is inserted per output packet.

## Interface
Parameters:
- `DATA_WD`, 32, data/header width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, byte lanes
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, header byte-count width
- `NUM_REQ`, 4, header requesters (2..16)
- `ID_WD`, `$clog2(NUM_REQ)`, grant id width

Ports:
- `clk` in 1: clock; all logic is on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester header valid.
- `req_data` in `NUM_REQ*DATA_WD`: headers; requester i occupies slice `[i*DATA_WD +: DATA_WD]`.
- `req_keep` in `NUM_REQ*DATA_BYTE_WD`: header keep, sliced the same way.
- `req_byte_cnt` in `NUM_REQ*BYTE_CNT_WD`: header byte counts, sliced the same way.
- `req_ready` out `NUM_REQ`: one-hot accept strobe to the winning requester.
- `valid_insert` out 1: header valid to `stream_insert`.
- `data_insert` out `DATA_WD`: latched header.
- `keep_insert` out `DATA_BYTE_WD`: latched keep.
- `byte_insert_cnt` out `BYTE_CNT_WD`: latched byte count.
- `ready_insert` in 1: `stream_insert` header accept.
- `pkt_last_fire` in 1: `valid_out && ready_out && last_out` of `stream_insert`.
- `grant_id` out `ID_WD`: index of the current owner.
- `busy` out 1: high in HDR or PKT.
- `proto_err` out 1: sticky protocol-error flag.

## Operation
- States: IDLE, HDR, PKT.
- **Round-robin pointer `rr_ptr`** (`ID_WD` bits, reset 0):
  - The winner is the first i with `req_valid[i]`, searching upward from `rr_ptr` and wrapping past `NUM_REQ-1` to 0.
  - On each grant, `rr_ptr` becomes `winner+1`, wrapping to 0 at `NUM_REQ`.
- **Grant event** occurs in IDLE when any `req_valid` is high, or in PKT when `pkt_last_fire` and any `req_valid` are high.
  - `req_ready[winner]` is high combinationally that cycle. It is the only `req_ready` bit ever high.
  - The winner's data, keep and byte_cnt are captured into the output registers.
  - `grant_id` takes the winner index.
  - The next state is HDR.
- **IDLE:** no request → stay in IDLE. `req_ready` is all zero.
- **HDR:**
  - `valid_insert` is 1.
  - The outputs stay stable until `valid_insert && ready_insert`, then the state moves to PKT.
  - `req_ready` is 0.
- **PKT:**
  - `valid_insert` is 0. The arbiter waits for `pkt_last_fire`.
  - On `pkt_last_fire`: grant event if a request is pending, otherwise go to IDLE.
- **`proto_err`** is set by `pkt_last_fire` in IDLE or HDR. Those events are otherwise ignored, with no state change. `proto_err` is cleared only by reset.
- Requesters that drop `req_valid` before receiving `req_ready` are legal and are not granted. A header is never accepted without its `req_ready` strobe.
- `req_valid` changing during HDR/PKT has no effect until the next grant event.

## Timing
- **Reset values:**
  - `valid_insert`, `req_ready`, `busy`, `proto_err` = 0.
  - `data_insert`, `keep_insert`, `byte_insert_cnt`, `grant_id` = 0.
  - State = IDLE, `rr_ptr` = 0.
- Reset mid-HDR or mid-PKT: all outputs return to reset values immediately (asynchronous). The header held in the output registers is discarded.
- Latency: `req_ready` in cycle N, then `valid_insert` = 1 in cycle N+1.
- Back-to-back: `pkt_last_fire` in cycle N with a pending request gives `req_ready` in cycle N and `valid_insert` in N+1, with no idle bubble.
- `req_ready` is combinational from `req_valid` and state. `valid_insert`, `data_insert`, `keep_insert`, `byte_insert_cnt`, `grant_id`, `busy` and `proto_err` are registered. There is no combinational path from `ready_insert` to `valid_insert` or `data_insert`.
- `valid_insert` never drops without `ready_insert` (AXI-stream rule). The insert outputs do not change while `valid_insert && !ready_insert`.

## Test plan
- **Single requester:**
  - Stimulus: `req_valid=4'b0100`, `req_data[2]=32'hA5A5_0001`, `byte_cnt=2`, `ready_insert=1`.
  - Required: `req_ready=4'b0100` in cycle 0; `valid_insert=1`, `data_insert=32'hA5A5_0001`, `byte_insert_cnt=2`, `grant_id=2` in cycle 1; PKT from cycle 2; IDLE one cycle after `pkt_last_fire`.
- **All four requesting continuously, packet length 3 beats:**
  - Required: grant order 0, 1, 2, 3, 0, 1.
  - Exactly one `valid_insert && ready_insert` between consecutive `pkt_last_fire` pulses.
- **Fairness skip:**
  - Stimulus: `rr_ptr=1` (after a grant to 0); `req_valid=4'b1001`.
  - Required: grant to 3, then to 0.
- **Backpressure:**
  - Stimulus: `ready_insert` held at 0 for 5 cycles in HDR.
  - Required: `valid_insert`, `data_insert` and `keep_insert` stay constant for all 5 cycles, and the state moves to PKT on the first cycle with `ready_insert=1`.
- **Protocol error:**
  - Stimulus: `pkt_last_fire=1` while in HDR.
  - Required: `proto_err=1` the next cycle, the state stays HDR, and the flag persists until reset.
- **Reset mid-PKT:**
  - Stimulus: `rstn` asserted low while in PKT with `grant_id=3`.
  - Required: all outputs reach reset values immediately; after release, `req_valid=4'b1000` is granted with `rr_ptr` starting from 0.
